// File: rtl/aes128_encrypt_iter.sv
// Iterative AES-128 encryption core: one cipher round per clock, one block in flight.
// Round keys come from a full key expansion of the latched key, indexed by the round counter.
module aes128_encrypt_iter #(
   parameter int NR    = 10,
   parameter int CNT_W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] plaintext,
   input  logic [127:0] key,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] ciphertext,
   output logic         busy
);

   typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // S-box as multiplicative inverse (a^254, so 0 maps to 0) followed by the affine map
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] r, sq;
      r  = 8'h01;
      sq = a;
      for (int i = 1; i < 8; i++) begin
         sq = gmul(sq, sq);
         r  = gmul(r, sq);
      end
      return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [127:0] sub_bytes(input logic [127:0] x);
      logic [127:0] y;
      y = '0;
      for (int i = 0; i < 16; i++) y[8*i +: 8] = sbox(x[8*i +: 8]);
      return y;
   endfunction

   function automatic logic [127:0] shift_rows(input logic [127:0] x);
      logic [127:0] y;
      y = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            y[127-8*(4*c+r) -: 8] = x[127-8*(4*((c+r)%4)+r) -: 8];
      return y;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] x);
      logic [127:0] y;
      logic [7:0]   a0, a1, a2, a3;
      y = '0;
      for (int c = 0; c < 4; c++) begin
         {a0, a1, a2, a3} = x[127-32*c -: 32];
         y[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                              a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                              a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                              xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
      end
      return y;
   endfunction

   function automatic logic [NR:0][127:0] key_expand(input logic [127:0] k);
      logic [31:0]         w [4*(NR+1)];
      logic [31:0]         t;
      logic [7:0]          rc;
      logic [NR:0][127:0] rks;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
      for (int i = 4; i < 4*(NR+1); i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = {sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0]), sbox(t[31:24])} ^ {rc, 24'h0};
            rc = xtime(rc);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r <= NR; r++) rks[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      return rks;
   endfunction

   state_t              st, st_nxt;
   logic [CNT_W-1:0]    round_cnt;
   logic [127:0]        state_reg, key_reg;
   logic [NR:0][127:0]  rks;
   logic [127:0]        rk, sr, mc;
   logic                last_round;

   assign rks        = key_expand(key_reg);
   assign rk         = rks[round_cnt];
   assign sr         = shift_rows(sub_bytes(state_reg));
   assign mc         = mix_columns(sr);
   assign last_round = (round_cnt == CNT_W'(NR));
   assign in_ready   = (st == IDLE);
   assign busy       = (st != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) st <= IDLE;
      else        st <= st_nxt;
   end

   always_comb begin
      st_nxt = st;
      case (st)
         IDLE:    if (in_valid)   st_nxt = ROUND;
         ROUND:   if (last_round) st_nxt = DONE;
         DONE:    if (out_ready)  st_nxt = IDLE;
         default: st_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         round_cnt  <= '0;
         state_reg  <= '0;
         key_reg    <= '0;
         ciphertext <= '0;
         out_valid  <= 1'b0;
      end else begin
         case (st)
            IDLE: if (in_valid) begin
               key_reg   <= key;
               state_reg <= plaintext ^ key;
               round_cnt <= CNT_W'(1);
            end
            ROUND: if (last_round) begin
               // final round skips MixColumns
               ciphertext <= sr ^ rk;
               out_valid  <= 1'b1;
            end else begin
               state_reg <= mc ^ rk;
               round_cnt <= round_cnt + 1'b1;
            end
            DONE: if (out_ready) out_valid <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_aes128_encrypt_iter.sv
// Bench for aes128_encrypt_iter: table-driven AES reference plus a cycle-level handshake model,
// compared against the DUT on every falling edge, with directed FIPS-197 vectors.
module tb_aes128_encrypt_iter;

   logic         clk = 1'b0;
   logic         rst_n, in_valid, in_ready, out_valid, out_ready, busy;
   logic [127:0] plaintext, key, ciphertext;
   int           checks = 0, failures = 0;

   localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] P2 = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] C2 = 128'h3925841d02dc09fbdc118597196a0b32;

   localparam logic [127:0] SBOX_ROWS [16] = '{
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

   aes128_encrypt_iter dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .plaintext(plaintext), .key(key), .out_valid(out_valid), .out_ready(out_ready),
      .ciphertext(ciphertext), .busy(busy));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=%h exp=%h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] sb(input logic [7:0] x);
      logic [127:0] row;
      row = SBOX_ROWS[x[7:4]];
      return row[127-8*int'(x[3:0]) -: 8];
   endfunction

   function automatic logic [7:0] x2(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // Byte-array reference with an on-the-fly key schedule
   function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] kin);
      logic [7:0]   s [16], k [16], t [16];
      logic [7:0]   rc, a0, a1, a2, a3;
      logic [127:0] res;
      for (int i = 0; i < 16; i++) begin
         k[i] = kin[127-8*i -: 8];
         s[i] = pt[127-8*i -: 8] ^ k[i];
      end
      rc = 8'h01;
      for (int r = 1; r <= 10; r++) begin
         k[0] = k[0] ^ sb(k[13]) ^ rc;
         k[1] = k[1] ^ sb(k[14]);
         k[2] = k[2] ^ sb(k[15]);
         k[3] = k[3] ^ sb(k[12]);
         for (int i = 4; i < 16; i++) k[i] = k[i] ^ k[i-4];
         rc = x2(rc);
         for (int i = 0; i < 16; i++) t[i] = sb(s[(i + 4*(i%4)) % 16]);
         for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            if (r < 10) begin
               s[4*c]   = x2(a0) ^ x2(a1) ^ a1 ^ a2 ^ a3;
               s[4*c+1] = a0 ^ x2(a1) ^ x2(a2) ^ a2 ^ a3;
               s[4*c+2] = a0 ^ a1 ^ x2(a2) ^ x2(a3) ^ a3;
               s[4*c+3] = x2(a0) ^ a0 ^ a1 ^ a2 ^ x2(a3);
            end else begin
               s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ k[i];
      end
      res = '0;
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   // Handshake model: accepted block appears 10 clocks later, held until taken
   logic         m_idle, m_ov;
   logic [127:0] m_ct, m_pend;
   int           m_cnt;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_idle <= 1'b1; m_ov <= 1'b0; m_ct <= '0; m_pend <= '0; m_cnt <= 0;
      end else if (m_ov) begin
         if (out_ready) begin m_ov <= 1'b0; m_idle <= 1'b1; end
      end else if (m_idle) begin
         if (in_valid) begin m_pend <= aes_ref(plaintext, key); m_cnt <= 10; m_idle <= 1'b0; end
      end else if (m_cnt == 1) begin
         m_ct <= m_pend; m_ov <= 1'b1;
      end else begin
         m_cnt <= m_cnt - 1;
      end
   end

   always @(negedge clk) begin
      chk("cyc_in_ready", 128'(in_ready), 128'(m_idle));
      chk("cyc_busy", 128'(busy), 128'(!m_idle));
      chk("cyc_out_valid", 128'(out_valid), 128'(m_ov));
      chk("cyc_ciphertext", ciphertext, m_ct);
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic send(input logic [127:0] pt, input logic [127:0] k);
      bit got;
      got = 1'b0;
      @(posedge clk); #1;
      plaintext = pt; key = k; in_valid = 1'b1;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge clk);
         if (in_ready) got = 1'b1;
         @(posedge clk);
      end
      #1 in_valid = 1'b0;
      if (!got) chk("accept_timeout", 128'd0, 128'd1);
   endtask

   // Returns on the first falling edge with out_valid high; n = clocks since accept
   task automatic wait_out(output int n);
      bit seen;
      seen = 1'b0;
      n = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
         else begin @(posedge clk); n++; end
      end
      if (!seen) chk("out_timeout", 128'd0, 128'd1);
   endtask

   initial begin
      int           n, cyc, nacc, nout;
      int           acc_c [2], out_c [2];
      logic [127:0] out_v [2];
      bit           acc_now, seen;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; plaintext = '0; key = '0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 128'(in_ready), 128'd1);
      chk("rst_out_valid", 128'(out_valid), 128'd0);
      chk("rst_busy", 128'(busy), 128'd0);
      chk("rst_ciphertext", ciphertext, 128'd0);
      rst_n = 1'b1;

      chk("model_T1", aes_ref(P1, K1), C1);
      chk("model_T2", aes_ref(P2, K2), C2);

      // T1: FIPS C.1 with latency
      out_ready = 1'b1;
      send(P1, K1);
      wait_out(n);
      chk("T1_latency", 128'(n), 128'd10);
      chk("T1_ct", ciphertext, C1);
      @(posedge clk); @(negedge clk);
      chk("T1_in_ready_after", 128'(in_ready), 128'd1);
      chk("T1_out_valid_after", 128'(out_valid), 128'd0);

      // T2: FIPS App.B with round-state trace
      send(P2, K2);
      @(negedge clk);
      chk("T2_round0_state", dut.state_reg, 128'h193de3bea0f4e22b9ac68d2ae9f84808);
      @(negedge clk);
      chk("T2_round1_state", dut.state_reg, 128'ha49c7ff2689f352b6b5bea43026a5049);
      wait_out(n);
      chk("T2_ct", ciphertext, C2);
      @(posedge clk); #1;

      // T3: backpressure
      out_ready = 1'b0;
      send(128'h0, {128{1'b1}});
      wait_out(n);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("T3_hold_valid", 128'(out_valid), 128'd1);
         chk("T3_hold_in_ready", 128'(in_ready), 128'd0);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("T3_released_valid", 128'(out_valid), 128'd0);
      chk("T3_released_in_ready", 128'(in_ready), 128'd1);

      // T4: input churn while rounds run
      send(P1, K1);
      seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
         else begin
            @(posedge clk); #1;
            plaintext = {$urandom, $urandom, $urandom, $urandom};
            key       = {$urandom, $urandom, $urandom, $urandom};
            in_valid  = ($urandom_range(0, 1) == 1);
         end
      end
      in_valid = 1'b0;
      chk("T4_seen", 128'(seen), 128'd1);
      chk("T4_ct", ciphertext, C1);

      // T5: async reset at round 5, then T2 again
      send(P2, K2);
      repeat (4) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("T5_busy", 128'(busy), 128'd0);
      chk("T5_in_ready", 128'(in_ready), 128'd1);
      chk("T5_out_valid", 128'(out_valid), 128'd0);
      chk("T5_ciphertext", ciphertext, 128'd0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      send(P2, K2);
      wait_out(n);
      chk("T5_ct", ciphertext, C2);
      @(posedge clk);

      // T6: back-to-back with in_valid held high
      @(posedge clk); #1;
      plaintext = P1; key = K1; in_valid = 1'b1;
      cyc = 0; nacc = 0; nout = 0;
      for (int i = 0; i < 80 && nout < 2; i++) begin
         @(negedge clk);
         if (out_valid) begin out_c[nout] = cyc; out_v[nout] = ciphertext; nout++; end
         acc_now = in_ready && in_valid;
         @(posedge clk);
         if (acc_now && nacc < 2) begin acc_c[nacc] = cyc; nacc++; end
         cyc++;
         #1;
         if (nacc == 1) begin plaintext = P2; key = K2; end
         else if (nacc == 2) in_valid = 1'b0;
      end
      in_valid = 1'b0;
      if (nout < 2 || nacc < 2) chk("T6_timeout", 128'd0, 128'd1);
      else begin
         chk("T6_ct0", out_v[0], C1);
         chk("T6_ct1", out_v[1], C2);
         chk("T6_latency", 128'(out_c[0] - acc_c[0] - 1), 128'd10);
         chk("T6_second_accept", 128'(acc_c[1]), 128'(out_c[0] + 1));
         // 10 round clocks + one DONE cycle + one IDLE cycle
         chk("T6_pulse_spacing", 128'(out_c[1] - out_c[0]), 128'd12);
      end
      repeat (2) @(posedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
